div_seq: RTL
============

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset; rst=0 forces reset immediately, independent of clk.
- start_i  in  1  request a divide; sampled only in IDLE.
- signed_i  in  1  1=DIV (signed), 0=DIVU (unsigned); captured with start_i.
- opa_i  in  32  dividend; captured with start_i.
- opb_i  in  32  divisor; captured with start_i.
- annul_i  in  1  pipeline flush; cancels any in-flight divide.
- stall_o  out  1  pipeline stall request.
- busy_o  out  1  a divide is in flight (state RUN or DZERO).
- done_o  out  1  one-cycle result-valid pulse.
- hilo_we_o  out  1  write enable to the HI/LO register pair; equals done_o.
- hi_o  out  32  remainder result for HI.
- lo_o  out  32  quotient result for LO.

Function
REQ-002 The block SHALL implement exactly four states: IDLE, RUN, DZERO and DONE.
REQ-003 In IDLE with start_i=1 and annul_i=0, the block SHALL latch opa_i, opb_i and signed_i on that edge.
REQ-004 On the same edge as REQ-003, the block SHALL go to DZERO if opb_i==0 and to RUN otherwise.
REQ-005 start_i in any state other than IDLE SHALL be ignored, and the latched operands SHALL be unchanged.
REQ-006 At the start edge, the block SHALL form operand magnitudes: for signed_i=1 it SHALL use the two's-complement absolute value, and for signed_i=0 it SHALL use the raw operand.
REQ-007 RUN SHALL perform restoring division at one quotient bit per edge, MSB first.
REQ-008 RUN SHALL use a 6-bit iteration counter and a 65-bit shift/remainder register.
REQ-009 RUN SHALL last exactly 32 edges, after which the block SHALL go to DONE.
REQ-010 DZERO SHALL last exactly one cycle and then go to DONE, with result hi=opa (the latched value, unmodified) and lo=32'hFFFF_FFFF.
REQ-011 On entry to DONE, hi_o and lo_o SHALL be registered with the sign-corrected result.
- Quotient is negated if signed and the operand signs differ.
- Remainder takes the sign of the dividend if signed.
REQ-012 A signed 32'h8000_0000 / 32'hFFFF_FFFF SHALL yield lo=32'h8000_0000 and hi=0, with no exception.
REQ-013 In DONE, done_o and hilo_we_o SHALL be 1 for exactly that one cycle, and the next edge SHALL go to IDLE.
REQ-014 hi_o and lo_o SHALL hold their value from the last DONE until the next DONE or until reset.
REQ-015 stall_o SHALL be a combinational output.
- stall_o = (IDLE and start_i and not annul_i) or RUN or DZERO.
- stall_o SHALL be 0 in DONE, so that the requesting instruction advances with the result.
REQ-016 busy_o SHALL be 1 in RUN and DZERO, and 0 otherwise.
REQ-017 annul_i=1 in RUN or DZERO SHALL return the block to IDLE on the next edge, with no done_o, no hilo_we_o, and hi_o/lo_o unchanged.
REQ-018 annul_i=1 in DONE SHALL NOT suppress the write, because the result is already committed in that cycle.
REQ-019 annul_i=1 in IDLE SHALL block acceptance of start_i in that same cycle.
REQ-020 Latency SHALL be as follows, counting from the start-sampling edge E0:
- Nonzero divisor: done_o is high in the cycle after edge E32.
- Zero divisor: done_o is high in the cycle after edge E1.
REQ-021 A new start_i SHALL be accepted in the cycle following DONE, at the earliest.

Reset
REQ-022 While rst=0, the state SHALL be IDLE and all internal registers SHALL be cleared.
REQ-023 While rst=0, hi_o, lo_o, done_o, hilo_we_o and busy_o SHALL be 0.
REQ-024 While rst=0, stall_o SHALL be 0 if start_i=0.
REQ-025 A reset asserted mid-RUN SHALL abort the divide immediately, with no write pulse after release.
REQ-026 After rst returns to 1, the block SHALL accept start_i on the first rising edge.

Verification
REQ-027 Unsigned divide: start, signed=0, opa=100, opb=7 -> done_o one cycle after E32, lo_o=14, hi_o=2, and hilo_we_o=1 for exactly one cycle.
REQ-028 Signed divide: start, signed=1, opa=-7 (32'hFFFF_FFF9), opb=2 -> lo_o=32'hFFFF_FFFD (-3) and hi_o=32'hFFFF_FFFF (-1).
REQ-029 Divide by zero: start, opb=0, opa=32'h1234_5678 -> done_o after E1, hi_o=32'h1234_5678, lo_o=32'hFFFF_FFFF, and busy_o=1 for exactly one cycle.
REQ-030 Overflow case: signed 32'h8000_0000 / 32'hFFFF_FFFF -> lo_o=32'h8000_0000 and hi_o=0.
REQ-031 Flush and restart:
- annul_i pulsed at E10 of a divide -> IDLE at the next edge, no done_o, and hi_o/lo_o keep their prior values.
- start_i pulsed while busy is ignored.
- A fresh start_i immediately after the flush completes normally.
REQ-032 Reset mid-operation: rst driven low between clock edges during RUN -> all outputs 0 immediately, and no hilo_we_o after release.

Source files
------------

// File: rtl/div_seq.sv
// Sequential 32-bit integer divider (DIV/DIVU) for a pipelined CPU.
// Restoring division, one quotient bit per clock, with annul and divide-by-zero handling.
module div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] opa_i,
  input  logic [31:0] opb_i,
  input  logic        annul_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {IDLE, RUN, DZERO, DONE} state_t;

  state_t      state, stateNext;
  logic [31:0] opaQ;
  logic [31:0] magbQ;
  logic        sgnQ, negaQ, negbQ;
  logic [5:0]  cnt;
  logic [64:0] acc;

  logic        accept;
  logic [31:0] magaIn, magbIn;
  logic [64:0] accShift, accStep;
  logic [32:0] diff;
  logic [31:0] quo, rem, quoFix, remFix;

  assign accept    = (state == IDLE) && start_i && !annul_i;
  assign busy_o    = (state == RUN) || (state == DZERO);
  assign done_o    = (state == DONE);
  assign hilo_we_o = done_o;
  assign stall_o   = accept || busy_o;

  assign magaIn = (signed_i && opa_i[31]) ? -opa_i : opa_i;
  assign magbIn = (signed_i && opb_i[31]) ? -opb_i : opb_i;

  // Borrow out of the 33-bit subtract means the trial subtraction failed: keep the shifted value.
  assign accShift = acc << 1;
  assign diff     = accShift[64:32] - {1'b0, magbQ};
  assign accStep  = diff[32] ? accShift : {diff, accShift[31:1], 1'b1};

  assign quo    = accStep[31:0];
  assign rem    = accStep[63:32];
  assign quoFix = (sgnQ && (negaQ ^ negbQ)) ? -quo : quo;
  assign remFix = (sgnQ && negaQ) ? -rem : rem;

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept) stateNext = (opb_i == 32'd0) ? DZERO : RUN;
      RUN:     if (annul_i) stateNext = IDLE;
               else if (cnt == 6'd31) stateNext = DONE;
      DZERO:   stateNext = annul_i ? IDLE : DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      opaQ  <= '0;
      magbQ <= '0;
      sgnQ  <= 1'b0;
      negaQ <= 1'b0;
      negbQ <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      hi_o  <= '0;
      lo_o  <= '0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: if (accept) begin
          opaQ  <= opa_i;
          sgnQ  <= signed_i;
          negaQ <= signed_i & opa_i[31];
          negbQ <= signed_i & opb_i[31];
          magbQ <= magbIn;
          acc   <= {33'd0, magaIn};
          cnt   <= '0;
        end
        RUN: if (!annul_i) begin
          acc <= accStep;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            hi_o <= remFix;
            lo_o <= quoFix;
          end
        end
        DZERO: if (!annul_i) begin
          hi_o <= opaQ;
          lo_o <= 32'hFFFF_FFFF;
        end
        default: ;
      endcase
    end
  end

endmodule
